// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush of FD/DE/EM/MW, PC hold, load-use bubbles and halt drain.
// Define HAZARD_PERF_EN to build the saturating performance counters; otherwise the counter ports read 0.
module hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int LOAD_BUBBLES = 1,
    parameter int HALT_DRAIN   = 2,
    parameter int CNT_W        = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic [REG_AW-1:0] fd_rs,
    input  logic [REG_AW-1:0] fd_rt,
    input  logic              fd_use_rs,
    input  logic              fd_use_rt,
    input  logic [REG_AW-1:0] de_rd,
    input  logic              de_memread,
    input  logic              de_redirect,
    input  logic              de_halt,
    input  logic              em_dren,
    input  logic              em_dwen,
    output logic [3:0]        stall,
    output logic [3:0]        flush,
    output logic              pc_hold,
    output logic              halt,
    output logic [CNT_W-1:0]  cnt_lduse,
    output logic [CNT_W-1:0]  cnt_redirect,
    output logic [CNT_W-1:0]  cnt_memwait
);

    typedef enum logic [1:0] {RUN, LDUSE, DRAIN, HALTED} stateT;

    stateT      state, stateNext;
    logic [1:0] bcnt, bcntNext;
    logic [2:0] dcnt, dcntNext;
    logic       memBusy;
    logic       ldHaz;

    assign memBusy = (em_dren | em_dwen) & ~dhit;
    assign ldHaz   = de_memread && (de_rd != '0) &&
                     ((fd_use_rs && (fd_rs == de_rd)) || (fd_use_rt && (fd_rt == de_rd)));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= RUN;
            bcnt  <= '0;
            dcnt  <= '0;
        end else begin
            state <= stateNext;
            bcnt  <= bcntNext;
            dcnt  <= dcntNext;
        end
    end

    // Prioritised decision: earlier branches fully override later ones.
    always_comb begin
        stateNext = state;
        bcntNext  = bcnt;
        dcntNext  = dcnt;
        stall     = 4'b0000;
        flush     = 4'b0000;
        pc_hold   = 1'b0;
        halt      = 1'b0;
        if (state == HALTED) begin
            stall   = 4'b1111;
            pc_hold = 1'b1;
            halt    = 1'b1;
        end else if (memBusy) begin
            stall   = 4'b0111;
            flush   = 4'b1000;
            pc_hold = 1'b1;
        end else if (state == DRAIN) begin
            flush   = 4'b0011;
            pc_hold = 1'b1;
            if (dcnt == 3'd0) begin
                stateNext = HALTED;
            end else begin
                dcntNext = dcnt - 3'd1;
            end
        end else if (de_halt) begin
            flush     = 4'b0011;
            pc_hold   = 1'b1;
            dcntNext  = 3'(HALT_DRAIN - 1);
            stateNext = DRAIN;
        end else if (de_redirect) begin
            flush     = 4'b0011;
            stateNext = RUN;
        end else if (state == LDUSE) begin
            stall   = 4'b0001;
            flush   = 4'b0010;
            pc_hold = 1'b1;
            if (bcnt == 2'd0) begin
                stateNext = RUN;
            end else begin
                bcntNext = bcnt - 2'd1;
            end
        end else if (ldHaz) begin
            stall   = 4'b0001;
            flush   = 4'b0010;
            pc_hold = 1'b1;
            if (LOAD_BUBBLES > 1) begin
                bcntNext  = 2'(LOAD_BUBBLES - 2);
                stateNext = LDUSE;
            end
        end else if (!ihit) begin
            flush   = 4'b0001;
            pc_hold = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic lduseAct, redirectAct, memwaitAct;

    // Each event has a unique output signature, so the counters decode the chosen branch from it.
    assign lduseAct    = (stall == 4'b0001);
    assign memwaitAct  = (stall == 4'b0111);
    assign redirectAct = (flush == 4'b0011) && !pc_hold;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_lduse    <= '0;
            cnt_redirect <= '0;
            cnt_memwait  <= '0;
        end else begin
            if (lduseAct && (cnt_lduse != '1)) cnt_lduse <= cnt_lduse + 1'b1;
            if (redirectAct && (cnt_redirect != '1)) cnt_redirect <= cnt_redirect + 1'b1;
            if (memwaitAct && (cnt_memwait != '1)) cnt_memwait <= cnt_memwait + 1'b1;
        end
    end
`else
    assign cnt_lduse    = '0;
    assign cnt_redirect = '0;
    assign cnt_memwait  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios then randomized traffic
// compared against a cycle-level behavioural model of the hazard priority rules.
module tb_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int LB     = 3;
    localparam int HD     = 3;
    localparam int CW     = 4;

    logic              CLK = 1'b0;
    logic              RST;
    logic              ihit, dhit, fd_use_rs, fd_use_rt;
    logic              de_memread, de_redirect, de_halt, em_dren, em_dwen;
    logic [REG_AW-1:0] fd_rs, fd_rt, de_rd;
    logic [3:0]        stall, flush;
    logic              pc_hold, halt;
    logic [CW-1:0]     cnt_lduse, cnt_redirect, cnt_memwait;

    int checkCount = 0;
    int errorCount = 0;

    // Model state: bubbles still owed, drain cycles still owed, halted flag, event counts.
    int mBubbles, mDrain, mLduse, mRedir, mMemwait;
    bit mHalted;
    int nBubbles, nDrain, nLduse, nRedir, nMemwait;
    bit nHalted;
    logic [3:0] eStall, eFlush;
    logic       ePc, eHalt;
    logic [3:0] obsStall, obsFlush;
    logic       obsHalt;

    hazard_ctrl #(.REG_AW(REG_AW), .LOAD_BUBBLES(LB), .HALT_DRAIN(HD), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_use_rs(fd_use_rs), .fd_use_rt(fd_use_rt),
        .de_rd(de_rd), .de_memread(de_memread), .de_redirect(de_redirect), .de_halt(de_halt),
        .em_dren(em_dren), .em_dwen(em_dwen),
        .stall(stall), .flush(flush), .pc_hold(pc_hold), .halt(halt),
        .cnt_lduse(cnt_lduse), .cnt_redirect(cnt_redirect), .cnt_memwait(cnt_memwait)
    );

    always #5 CLK = ~CLK;

    function automatic int satInc(input int v);
        return (v < (1 << CW) - 1) ? v + 1 : v;
    endfunction

    function automatic int expCnt(input int v);
`ifdef HAZARD_PERF_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic resetModel();
        mBubbles = 0; mDrain = 0; mHalted = 0;
        mLduse = 0; mRedir = 0; mMemwait = 0;
    endtask

    task automatic evalModel();
        bit busy, haz;
        busy = (em_dren || em_dwen) && !dhit;
        haz  = de_memread && (de_rd != 0) &&
               ((fd_use_rs && fd_rs == de_rd) || (fd_use_rt && fd_rt == de_rd));
        eStall = 4'h0; eFlush = 4'h0; ePc = 1'b0; eHalt = 1'b0;
        nBubbles = mBubbles; nDrain = mDrain; nHalted = mHalted;
        nLduse = mLduse; nRedir = mRedir; nMemwait = mMemwait;
        if (mHalted) begin
            eStall = 4'hF; ePc = 1'b1; eHalt = 1'b1;
        end else if (busy) begin
            eStall = 4'h7; eFlush = 4'h8; ePc = 1'b1;
            nMemwait = satInc(mMemwait);
        end else if (mDrain > 0) begin
            eFlush = 4'h3; ePc = 1'b1;
            nDrain = mDrain - 1;
            if (nDrain == 0) nHalted = 1'b1;
        end else if (de_halt) begin
            eFlush = 4'h3; ePc = 1'b1;
            nDrain = HD; nBubbles = 0;
        end else if (de_redirect) begin
            eFlush = 4'h3;
            nBubbles = 0;
            nRedir = satInc(mRedir);
        end else if (mBubbles > 0) begin
            eStall = 4'h1; eFlush = 4'h2; ePc = 1'b1;
            nBubbles = mBubbles - 1;
            nLduse = satInc(mLduse);
        end else if (haz) begin
            eStall = 4'h1; eFlush = 4'h2; ePc = 1'b1;
            nBubbles = LB - 1;
            nLduse = satInc(mLduse);
        end else if (!ihit) begin
            eFlush = 4'h1; ePc = 1'b1;
        end
    endtask

    task automatic compareAll();
        checkOutput("stall", 32'(stall), 32'(eStall));
        checkOutput("flush", 32'(flush), 32'(eFlush));
        checkOutput("pc_hold", 32'(pc_hold), 32'(ePc));
        checkOutput("halt", 32'(halt), 32'(eHalt));
        checkOutput("cnt_lduse", 32'(cnt_lduse), expCnt(mLduse));
        checkOutput("cnt_redirect", 32'(cnt_redirect), expCnt(mRedir));
        checkOutput("cnt_memwait", 32'(cnt_memwait), expCnt(mMemwait));
    endtask

    task automatic stepCycle();
        @(negedge CLK);
        evalModel();
        compareAll();
        obsStall = stall; obsFlush = flush; obsHalt = halt;
        mBubbles = nBubbles; mDrain = nDrain; mHalted = nHalted;
        mLduse = nLduse; mRedir = nRedir; mMemwait = nMemwait;
        @(posedge CLK);
        #1;
    endtask

    // Asynchronous reset pulse between clock edges; outputs must react without a clock.
    task automatic pulseReset();
        RST = 1'b1;
        #1;
        resetModel();
        evalModel();
        compareAll();
        RST = 1'b0;
        #1;
    endtask

    task automatic setIdle();
        ihit = 1'b1; dhit = 1'b1;
        fd_rs = '0; fd_rt = '0; fd_use_rs = 1'b0; fd_use_rt = 1'b0;
        de_rd = '0; de_memread = 1'b0; de_redirect = 1'b0; de_halt = 1'b0;
        em_dren = 1'b0; em_dwen = 1'b0;
    endtask

    task automatic setLoadUse();
        de_memread = 1'b1; de_rd = 5'd8; fd_rs = 5'd8; fd_use_rs = 1'b1;
    endtask

    task automatic applyStimulus();
        ihit        = ($urandom_range(0, 7) != 0);
        dhit        = ($urandom_range(0, 3) != 0);
        em_dren     = ($urandom_range(0, 3) == 0);
        em_dwen     = ($urandom_range(0, 5) == 0);
        fd_rs       = 5'($urandom_range(0, 3));
        fd_rt       = 5'($urandom_range(0, 3));
        de_rd       = 5'($urandom_range(0, 3));
        fd_use_rs   = 1'($urandom_range(0, 1));
        fd_use_rt   = 1'($urandom_range(0, 1));
        de_memread  = ($urandom_range(0, 2) == 0);
        de_redirect = ($urandom_range(0, 7) == 0);
        de_halt     = ($urandom_range(0, 39) == 0);
    endtask

    initial begin
        int tally;
        int riseAt;
        setIdle();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        resetModel();
        evalModel();
        compareAll();
        RST = 1'b0;
        #1;

        // Load-use bubble length
        setLoadUse();
        tally = 0;
        for (int i = 0; i < LB; i++) begin
            stepCycle();
            if (obsStall == 4'b0001 && obsFlush == 4'b0010) tally++;
        end
        setIdle();
        stepCycle();
        checkOutput("lduseLen", tally, LB);
        checkOutput("cntLduseTotal", 32'(cnt_lduse), expCnt(LB));

        // r0 never creates a hazard; redirect beats a simultaneous load-use
        de_memread = 1'b1; de_rd = '0; fd_rs = '0; fd_use_rs = 1'b1;
        stepCycle();
        setIdle();
        de_memread = 1'b1; de_rd = 5'd5; fd_rt = 5'd5; fd_use_rt = 1'b1; de_redirect = 1'b1;
        stepCycle();
        checkOutput("redirOverLd", 32'({obsStall, obsFlush}), 32'h03);

        // Memory wait in the middle of a load-use bubble
        pulseReset();
        setIdle();
        setLoadUse();
        stepCycle();
        setIdle();
        em_dren = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) stepCycle();
        setIdle();
        tally = 0;
        for (int i = 0; i < LB; i++) begin
            stepCycle();
            if (obsStall == 4'b0001) tally++;
        end
        checkOutput("lduseResume", tally, LB - 1);
        checkOutput("cntMemwait", 32'(cnt_memwait), expCnt(3));

        // Fetch miss alone and together with a memory wait
        ihit = 1'b0;
        stepCycle();
        em_dwen = 1'b1; dhit = 1'b0;
        stepCycle();
        setIdle();

        // Halt drain then async release
        pulseReset();
        de_halt = 1'b1;
        stepCycle();
        de_halt = 1'b0;
        riseAt = -1;
        for (int i = 1; i <= 12; i++) begin
            stepCycle();
            if (obsHalt && riseAt < 0) riseAt = i;
        end
        checkOutput("haltRise", riseAt, HD + 1);
        pulseReset();
        checkOutput("haltAfterRst", 32'(halt), 0);

        // Redirect counter saturation
        pulseReset();
        de_redirect = 1'b1;
        for (int i = 0; i < 20; i++) stepCycle();
        setIdle();
        stepCycle();
        checkOutput("cntRedirSat", 32'(cnt_redirect), expCnt((1 << CW) - 1));

        // Randomized traffic with occasional resets
        pulseReset();
        for (int i = 0; i < 3000; i++) begin
            applyStimulus();
            stepCycle();
            if ((mHalted && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0) pulseReset();
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage core, driving stall/flush of the FD, DE, EM and MW latches plus PC hold. It extends the original combinational hazard unit with:
- a registered load-use bubble counter for configurable load-to-use distance
- a halt-drain state machine that retires in-flight instructions before asserting halt
- optional saturating performance counters

## Interface
Parameters:
- REG_AW, 5, register-index width
- LOAD_BUBBLES, 1, bubbles inserted per load-use hazard (legal 1..3)
- HALT_DRAIN, 2, cycles EM/MW are allowed to retire after a halt reaches DE (legal 1..7)
- CNT_W, 32, performance counter width

Ports (latch index 0=FD, 1=DE, 2=EM, 3=MW):
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- fd_rs, fd_rt  in  REG_AW  source registers of instruction in FD latch
- fd_use_rs, fd_use_rt  in  1  FD instruction actually reads rs / rt
- de_rd  in  REG_AW  destination of DE instruction
- de_memread  in  1  DE instruction is a load
- de_redirect  in  1  DE resolved a taken branch/jump (PC must redirect)
- de_halt  in  1  DE instruction is HALT
- em_dren, em_dwen  in  1  EM instruction reading / writing data memory
- stall  out  4  hold latch contents
- flush  out  4  load bubble (nop) into latch
- pc_hold  out  1  PC must not advance
- halt  out  1  CPU halted (sticky until RST)
- cnt_lduse, cnt_redirect, cnt_memwait  out  CNT_W each  performance counters

## Operation
- mem_busy = (em_dren | em_dwen) & !dhit. ldhaz = de_memread & de_rd!=0 & ((fd_use_rs & fd_rs==de_rd) | (fd_use_rt & fd_rt==de_rd)).
- States: RUN, LDUSE, DRAIN, HALTED. Register bcnt (2 bits), dcnt (3 bits).
- Priority each cycle, first match wins:
  - HALTED: stall=1111, flush=0000, pc_hold=1, halt=1.
  - mem_busy, any non-HALTED state: stall=0111, flush=1000, pc_hold=1. State and counters frozen.
  - DRAIN: flush=0011, stall=0000, pc_hold=1. dcnt decrements. At dcnt==0, go to HALTED.
  - de_halt (RUN/LDUSE): flush=0011, pc_hold=1. dcnt<=HALT_DRAIN-1, go to DRAIN.
  - de_redirect: flush=0011, pc_hold=0 (PC takes target). Aborts LDUSE; go to RUN.
  - LDUSE: stall=0001, flush=0010, pc_hold=1. bcnt decrements. At bcnt==0, go to RUN.
  - ldhaz (RUN): stall=0001, flush=0010, pc_hold=1. If LOAD_BUBBLES>1, bcnt<=LOAD_BUBBLES-2 and go to LDUSE.
  - !ihit: flush=0001, pc_hold=1.
  - otherwise: all 0.
- A latch never has stall and flush both asserted.

## Timing
- All outputs except counters are Mealy: combinational from current state and inputs, valid same cycle. State, bcnt, dcnt and counters update on rising CLK.
- Reset values:
  - state=RUN, bcnt=0, dcnt=0
  - stall=0000, flush=0000, pc_hold=0, halt=0
  - counters=0
- RST asserted mid-DRAIN, mid-LDUSE or in HALTED returns to RUN immediately (async). halt drops without waiting for CLK.
- Load-use cost is exactly LOAD_BUBBLES cycles when no mem_busy intervenes. mem_busy cycles extend it one-for-one.
- Halt: halt rises exactly HALT_DRAIN+1 cycles after the de_halt cycle, plus one per mem_busy cycle in between.

## Configuration
- HAZARD_PERF_EN defined: counters count cycles, saturating at all-ones, no wrap.
  - cnt_lduse: cycles with ldhaz-in-RUN or LDUSE output active
  - cnt_redirect: de_redirect accepted
  - cnt_memwait: mem_busy
  - Counters freeze in HALTED.
- HAZARD_PERF_EN undefined: ports remain, tied to 0, no counter flops.

## Test plan
- Load-use, LOAD_BUBBLES=2: de_memread=1, de_rd=8, fd_rs=8, fd_use_rs=1 -> stall=0001 and flush=0010 for exactly 2 cycles, then RUN. cnt_lduse=2.
- de_rd=0 with matching fd_rs=0 -> no stall. ldhaz and de_redirect in the same cycle -> flush=0011, stall=0000.
- em_dren=1, dhit=0 for 3 cycles during LDUSE -> stall=0111, flush=1000 each cycle, bcnt unchanged. Bubble resumes after dhit=1. cnt_memwait=3.
- de_halt with HALT_DRAIN=2, no mem traffic -> flush=0011 for 2 cycles, halt=1 on the third cycle and held. RST pulse -> halt=0 immediately.
- Counter saturation, CNT_W=4: 20 redirects -> cnt_redirect=15. Without HAZARD_PERF_EN -> all counters 0.
- ihit=0 alone -> flush=0001, pc_hold=1. ihit=0 with mem_busy -> stall=0111, flush=1000.
